// File: rtl/logic_unit_pkg.sv
// Shared types and defaults for the shared bitwise logic unit and its arbiter.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    LOP_AND  = 2'd0,
    LOP_OR   = 2'd1,
    LOP_XOR  = 2'd2,
    LOP_ANDN = 2'd3
  } logic_op_e;

  localparam int unsigned WIDTH_DEF = 32;

endpackage

// File: rtl/logic_unit_arbiter_rr.sv
// Round-robin arbiter: one-hot grant scanning upward from a rotating pointer.
// The pointer moves past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // First requester at or after ptr_q, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req_i[PW'(idx)]) begin
        gnt_o[PW'(idx)] = 1'b1;
        ptr_d           = PW'((idx + 1) % N);
        found           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit (AND/OR/XOR/ANDN) between NUM_REQ requesters,
// returning each result on a single registered response channel tagged by id.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = WIDTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b_i,
  input  logic [NUM_REQ*2-1:0]       req_op_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [WIDTH-1:0]           rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic               can_accept;
  logic               arb_en;
  logic               xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   result;
  logic_op_e          op_sel;
  logic [ID_W-1:0]    id_sel;

  // Slot is free when empty or being drained this cycle; nothing is accepted in reset.
  assign can_accept  = !rsp_valid_o || rsp_ready_i;
  assign arb_en      = can_accept && rst_ni;
  assign req_ready_o = gnt & {NUM_REQ{arb_en}};
  assign xfer        = |req_ready_o;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_valid_i),
    .en_i   (arb_en),
    .gnt_o  (gnt)
  );

  // Operand/op/id mux driven by the one-hot grant.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = LOP_AND;
    id_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        a_sel  = req_a_i[k*WIDTH +: WIDTH];
        b_sel  = req_b_i[k*WIDTH +: WIDTH];
        op_sel = logic_op_e'(req_op_i[k*2 +: 2]);
        id_sel = ID_W'(k);
      end
    end
  end

  always_comb begin
    result = '0;
    unique case (op_sel)
      LOP_AND:  result = a_sel & b_sel;
      LOP_OR:   result = a_sel | b_sel;
      LOP_XOR:  result = a_sel ^ b_sel;
      LOP_ANDN: result = a_sel & ~b_sel;
      default:  result = '0;
    endcase
  end

  // Response register; data/id only change on a transfer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
    end else if (xfer) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= result;
      rsp_id_o    <= id_sel;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus a
// randomized run scored against a per-requester FIFO reference model.
module tb_logic_unit_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;

  int ntests = 0;
  int nfail  = 0;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  // First valid requester at or after p, wrapping; -1 when none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_of(input int k);
    return ref_op(req_a[k*W +: W], req_b[k*W +: W], req_op[k*2 +: 2]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] op);
    req_valid[k]     = v;
    req_a[k*W +: W]  = a;
    req_b[k*W +: W]  = b;
    req_op[k*2 +: 2] = op;
  endtask

  task automatic test_reset();
    logic [W-1:0] e0;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
    e0 = exp_of(0);
    for (int c = 0; c < 3; c++) begin
      step();
      ntests++;
      if (req_ready !== 4'b0000) begin
        nfail++; $display("FAIL reset_ready: got %b exp 0000", req_ready);
      end
      ntests++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 2'd0) begin
        nfail++; $display("FAIL reset_rsp: got v=%b d=%h id=%0d exp v=0 d=0 id=0", rsp_valid, rsp_data, rsp_id);
      end
    end
    rst_n = 1'b1;
    #1;
    ntests++;
    if (req_ready !== 4'b0001) begin
      nfail++; $display("FAIL reset_first_grant: got %b exp 0001", req_ready);
    end
    step();
    req_valid = '0;
    ntests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== e0) begin
      nfail++; $display("FAIL reset_first_rsp: got v=%b id=%0d d=%h exp v=1 id=0 d=%h", rsp_valid, rsp_id, rsp_data, e0);
    end
  endtask

  task automatic test_single_op();
    logic [W-1:0] exp_tab [4];
    exp_tab[0] = 32'h00F0_000F;
    exp_tab[1] = 32'hFFF0_FFFF;
    exp_tab[2] = 32'hFF00_FFF0;
    exp_tab[3] = 32'hF000_00F0;
    rsp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      set_req(1, 1'b1, 32'hF0F0_00FF, 32'h0FF0_FF0F, 2'(op));
      #1;
      ntests++;
      if (req_ready !== 4'b0010) begin
        nfail++; $display("FAIL single_ready op%0d: got %b exp 0010", op, req_ready);
      end
      step();
      req_valid = '0;
      ntests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== exp_tab[op]) begin
        nfail++; $display("FAIL single_rsp op%0d: got v=%b id=%0d d=%h exp v=1 id=1 d=%h",
                          op, rsp_valid, rsp_id, rsp_data, exp_tab[op]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [W-1:0] e;
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
    for (int c = 0; c < 8; c++) begin
      #1;
      ntests++;
      if (req_ready !== 4'(1 << (c % N))) begin
        nfail++; $display("FAIL fair_grant c%0d: got %b exp %b", c, req_ready, 4'(1 << (c % N)));
      end
      e = exp_of(c % N);
      step();
      ntests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % N) || rsp_data !== e) begin
        nfail++; $display("FAIL fair_rsp c%0d: got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                          c, rsp_valid, rsp_id, rsp_data, c % N, e);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0;
    logic [W-1:0] d2;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    set_req(0, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
    d0 = exp_of(0);
    rsp_ready = 1'b0;
    #1;
    ntests++;
    if (req_ready !== 4'b0001) begin
      nfail++; $display("FAIL bp_load_ready: got %b exp 0001", req_ready);
    end
    step();
    req_valid[0] = 1'b0;
    set_req(2, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
    d2 = exp_of(2);
    for (int c = 0; c < 5; c++) begin
      #1;
      ntests++;
      if (req_ready !== 4'b0000) begin
        nfail++; $display("FAIL bp_ready c%0d: got %b exp 0000", c, req_ready);
      end
      ntests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== d0) begin
        nfail++; $display("FAIL bp_hold c%0d: got v=%b id=%0d d=%h exp v=1 id=0 d=%h",
                          c, rsp_valid, rsp_id, rsp_data, d0);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    ntests++;
    if (req_ready !== 4'b0100) begin
      nfail++; $display("FAIL bp_release_ready: got %b exp 0100", req_ready);
    end
    step();
    req_valid = '0;
    ntests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== d2) begin
      nfail++; $display("FAIL bp_release_rsp: got v=%b id=%0d d=%h exp v=1 id=2 d=%h", rsp_valid, rsp_id, rsp_data, d2);
    end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] e0;
    rsp_ready = 1'b0;
    req_valid = '0;
    set_req(3, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
    rst_n = 1'b0;
    #1;
    ntests++;
    if (req_ready !== 4'b0000) begin
      nfail++; $display("FAIL mid_reset_ready: got %b exp 0000", req_ready);
    end
    step();
    ntests++;
    if (rsp_valid !== 1'b0) begin
      nfail++; $display("FAIL mid_reset_flush: got v=%b exp v=0", rsp_valid);
    end
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
    e0 = exp_of(0);
    #1;
    ntests++;
    if (req_ready !== 4'b0001) begin
      nfail++; $display("FAIL mid_reset_ptr: got %b exp 0001", req_ready);
    end
    step();
    req_valid = '0;
    ntests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== e0) begin
      nfail++; $display("FAIL mid_reset_rsp: got v=%b id=%0d d=%h exp v=1 id=0 d=%h", rsp_valid, rsp_id, rsp_data, e0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q [N][$];
    logic [N-1:0] held;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] e;
    logic         exp_valid;
    int           ptr;
    int           g;
    int           nxfer;
    int           npop;
    int           left;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    rst_n     = 1'b1;
    held      = '0;
    exp_valid = 1'b0;
    ptr       = 0;
    nxfer     = 0;
    npop      = 0;

    for (int c = 0; c < 1001; c++) begin
      if (c < 1000) begin
        for (int k = 0; k < N; k++) begin
          if (!held[k]) set_req(k, $urandom_range(0, 99) < 55, $urandom, $urandom, 2'($urandom_range(0, 3)));
        end
        rsp_ready = $urandom_range(0, 99) < 70;
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      #1;
      g       = (!exp_valid || rsp_ready) ? pick(req_valid, ptr) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      ntests++;
      if (req_ready !== exp_rdy) begin
        nfail++; $display("FAIL rand_ready c%0d: got %b exp %b", c, req_ready, exp_rdy);
      end
      ntests++;
      if (rsp_valid !== exp_valid) begin
        nfail++; $display("FAIL rand_rsp_valid c%0d: got %b exp %b", c, rsp_valid, exp_valid);
      end
      if (exp_valid && rsp_ready) begin
        ntests++;
        if (q[rsp_id].size() == 0) begin
          nfail++; $display("FAIL rand_dup c%0d: got rsp for id=%0d exp none pending", c, rsp_id);
        end else begin
          e = q[rsp_id].pop_front();
          npop++;
          if (rsp_data !== e) begin
            nfail++; $display("FAIL rand_data c%0d id=%0d: got %h exp %h", c, rsp_id, rsp_data, e);
          end
        end
      end
      if (g >= 0) begin
        q[g].push_back(exp_of(g));
        ptr       = (g + 1) % N;
        exp_valid = 1'b1;
        nxfer++;
      end else if (rsp_ready) begin
        exp_valid = 1'b0;
      end
      for (int k = 0; k < N; k++) held[k] = req_valid[k] && (k != g);
      step();
    end

    left = 0;
    for (int k = 0; k < N; k++) left += q[k].size();
    ntests++;
    if (left != 0 || npop != nxfer || nxfer == 0) begin
      nfail++; $display("FAIL rand_lost: got popped=%0d pending=%0d exp popped=%0d pending=0", npop, left, nxfer);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    #1;
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
